// File: rtl/mul_share_arbiter_pkg.sv
// mul_share_arbiter_pkg: shared widths and FSM state encoding for the multiplier-sharing arbiter
package mul_share_arbiter_pkg;
  localparam int OP_W = 8;
  localparam int PROD_W = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_e;
endpackage

// File: rtl/mul_share_arbiter_if.sv
// mul_share_arbiter_if: client-side request/grant/response bus; master = requesters, slave = arbiter
interface mul_share_arbiter_if
  import mul_share_arbiter_pkg::*;
#(parameter int NUM_REQ = 4) ();
  logic [NUM_REQ-1:0] req;
  logic [OP_W*NUM_REQ-1:0] req_a;
  logic [OP_W*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [PROD_W-1:0] rsp_prod;
  logic rsp_err;
  logic [NUM_REQ-1:0] rsp_ack;
  modport master (output req, req_a, req_b, rsp_ack, input gnt, rsp_valid, rsp_prod, rsp_err);
  modport slave (input req, req_a, req_b, rsp_ack, output gnt, rsp_valid, rsp_prod, rsp_err);
endinterface

// File: rtl/mul_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; lowest set request at or above ptr wins, else wraps to lowest overall
module rr_pick #(
  parameter int N = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  logic [N-1:0] hi;
  logic [N-1:0] cand;
  always_comb begin
    hi = req & ~((N'(1) << ptr) - N'(1));
    cand = |hi ? hi : req;
    idx = '0;
    for (int j = N - 1; j >= 0; j--) idx = cand[j] ? IDX_W'(j) : idx;
    any = |req;
    onehot = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one sequential 8x8 multiplier among NUM_REQ clients,
// with registered grant, load sequencing, timeout abort and valid/ack response return.
module mul_share_arbiter
  import mul_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 32,
  parameter int IDX_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  mul_share_arbiter_if.slave bus,
  output logic              mul_load,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic [PROD_W-1:0] mul_prod,
  input  logic              mul_ready,
  output logic              busy
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, win_q, win_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, rsp_valid_q, rsp_valid_d;
  logic [PROD_W-1:0] rsp_prod_q, rsp_prod_d;
  logic rsp_err_q, rsp_err_d, mul_load_q, mul_load_d, busy_q, busy_d;
  logic [OP_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic pick_any, ready_ok, timed_out;
  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req(bus.req), .ptr(ptr_q), .onehot(pick_oh), .idx(pick_idx), .any(pick_any)
  );
  // the first WAIT cycle coincides with mul_load, so ready there still belongs to the previous job
  assign ready_ok = cnt_q != '0 && mul_ready;
  assign timed_out = cnt_q == CNT_W'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    win_d = win_q;
    gnt_d = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_prod_d = rsp_prod_q;
    rsp_err_d = rsp_err_q;
    mul_load_d = 1'b0;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (pick_any) begin
        gnt_d = pick_oh;
        win_d = pick_idx;
        mul_a_d = bus.req_a[pick_idx*OP_W +: OP_W];
        mul_b_d = bus.req_b[pick_idx*OP_W +: OP_W];
        state_d = LOAD;
      end
      LOAD: begin
        mul_load_d = 1'b1;
        cnt_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ready_ok || timed_out) begin
          rsp_valid_d = NUM_REQ'(1) << win_q;
          rsp_prod_d = ready_ok ? mul_prod : '0;
          rsp_err_d = !ready_ok;
          state_d = RESP;
        end
      end
      RESP: if (bus.rsp_ack[win_q]) begin
        rsp_valid_d = '0;
        rsp_err_d = 1'b0;
        ptr_d = win_q == IDX_W'(NUM_REQ - 1) ? '0 : win_q + IDX_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      win_q <= '0;
      gnt_q <= '0;
      rsp_valid_q <= '0;
      rsp_prod_q <= '0;
      rsp_err_q <= 1'b0;
      mul_load_q <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      win_q <= win_d;
      gnt_q <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_prod_q <= rsp_prod_d;
      rsp_err_q <= rsp_err_d;
      mul_load_q <= mul_load_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_prod = rsp_prod_q;
  assign bus.rsp_err = rsp_err_q;
  assign mul_load = mul_load_q;
  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed and random stimulus checked against a transaction-level arbitration model
module tb_mul_share_arbiter;
  localparam int N = 4;
  localparam int TO = 32;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mul_load, busy;
  logic [7:0] mul_a, mul_b;
  logic mul_ready = 1'b1;
  logic [15:0] mul_prod = 16'hDEAD;
  mul_share_arbiter_if #(.NUM_REQ(N)) bus ();
  mul_share_arbiter #(.NUM_REQ(N), .TIMEOUT(TO), .IDX_W(2)) dut (
    .clk(clk), .reset(reset), .bus(bus), .mul_load(mul_load), .mul_a(mul_a), .mul_b(mul_b),
    .mul_prod(mul_prod), .mul_ready(mul_ready), .busy(busy)
  );
  always #5 clk = ~clk;
  // behavioural multiplier: restart on load, ready after lat cycles, frozen while stall is set
  int lat = 3;
  bit stall = 1'b0;
  int m_cnt = 0;
  bit m_run = 1'b0;
  logic [7:0] m_a, m_b;
  always @(posedge clk) begin
    if (mul_load === 1'b1) begin
      m_run <= 1'b1;
      m_cnt <= lat;
      m_a <= mul_a;
      m_b <= mul_b;
      mul_ready <= 1'b0;
    end else if (m_run && !stall) begin
      if (m_cnt <= 1) begin
        m_run <= 1'b0;
        mul_ready <= 1'b1;
        mul_prod <= 16'(m_a) * 16'(m_b);
      end else m_cnt <= m_cnt - 1;
    end
  end
  logic [N-1:0] req_v = '0;
  logic [7:0] a_m [N];
  logic [7:0] b_m [N];
  logic [15:0] prod_by [N];
  int ptr_m = 0, cyc = 0, out_win = 0, t_gnt = 0, t_rsp = 0, ack_wait = 0, n_gnt = 0, n_load = 0, t_req = 0;
  bit out_act = 1'b0, in_resp = 1'b0, ack_sent = 1'b0, out_err = 1'b0, last_err = 1'b0;
  logic [7:0] out_a, out_b;
  logic [15:0] last_prod;
  int order[$];
  int errors = 0, checks = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int pick();
    for (int i = 0; i < N; i++) if (req_v[(ptr_m + i) % N]) return (ptr_m + i) % N;
    return -1;
  endfunction
  task automatic drive();
    bus.req = req_v;
    for (int i = 0; i < N; i++) begin
      bus.req_a[8*i +: 8] = a_m[i];
      bus.req_b[8*i +: 8] = b_m[i];
    end
  endtask
  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
    a_m[i] = a;
    b_m[i] = b;
    req_v[i] = 1'b1;
    drive();
  endtask
  task automatic step();
    int w;
    @(negedge clk);
    cyc++;
    if (ack_sent) begin
      chk("valid_clear", 32'(bus.rsp_valid), 0);
      chk("gnt_after_ack", 32'(bus.gnt), 0);
      ack_sent = 1'b0;
      bus.rsp_ack = '0;
    end
    if (mul_load) begin
      n_load++;
      if (out_act) chk("mul_ab", {mul_a, mul_b}, {out_a, out_b});
      else chk("mul_load_idle", 32'(mul_load), 0);
    end
    if (bus.gnt != '0) begin
      chk("gnt_when_busy", 32'(out_act), 0);
      w = pick();
      chk("gnt", 32'(bus.gnt), w < 0 ? 0 : 1 << w);
      if (w >= 0) begin
        out_act = 1'b1;
        out_win = w;
        out_a = a_m[w];
        out_b = b_m[w];
        out_err = stall;
        t_gnt = cyc;
        n_gnt++;
        order.push_back(w);
        req_v[w] = 1'b0;
      end
    end
    if (in_resp) begin
      chk("rsp_hold", 32'(bus.rsp_valid), 1 << out_win);
      if (ack_wait == 0) begin
        bus.rsp_ack = (N'(1) << out_win) | N'($urandom);
        ptr_m = (out_win + 1) % N;
        out_act = 1'b0;
        in_resp = 1'b0;
        ack_sent = 1'b1;
      end else begin
        ack_wait--;
        bus.rsp_ack = N'($urandom) & ~(N'(1) << out_win);
      end
    end else if (bus.rsp_valid != '0) begin
      chk("rsp_valid", 32'(bus.rsp_valid), out_act ? 1 << out_win : 0);
      if (out_act) begin
        chk("rsp_err", 32'(bus.rsp_err), 32'(out_err));
        chk("rsp_prod", 32'(bus.rsp_prod), out_err ? 0 : 32'(16'(out_a) * 16'(out_b)));
        t_rsp = cyc - t_gnt;
        last_prod = bus.rsp_prod;
        last_err = bus.rsp_err;
        prod_by[out_win] = bus.rsp_prod;
        in_resp = 1'b1;
        ack_wait = $urandom_range(0, 2);
        bus.rsp_ack = N'($urandom) & ~(N'(1) << out_win);
      end
    end
    drive();
  endtask
  task automatic drain();
    int n = 0;
    while ((req_v != '0 || out_act) && n < 400) begin
      step();
      n++;
    end
    chk("drain_budget", 32'(n < 400), 1);
    step();
    chk("busy_idle", 32'(busy), 0);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 0);
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 0);
    chk({tag, "_prod"}, 32'(bus.rsp_prod), 0);
    chk({tag, "_err"}, 32'(bus.rsp_err), 0);
    chk({tag, "_load"}, 32'(mul_load), 0);
    chk({tag, "_ab"}, {mul_a, mul_b}, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      a_m[i] = '0;
      b_m[i] = '0;
    end
    bus.rsp_ack = '0;
    drive();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    set_req(0, 8'h0F, 8'h09);
    t_req = cyc;
    drain();
    chk("s1_gnt_lat", 32'(t_gnt - t_req), 1);
    chk("s1_ngnt", 32'(n_gnt), 1);
    chk("s1_nload", 32'(n_load), 1);
    chk("s1_prod", 32'(last_prod), 32'h0087);
    chk("s1_err", 32'(last_err), 0);
    set_req(3, 8'h02, 8'h03);
    drain();
    order.delete();
    set_req(0, 8'd3, 8'd5);
    set_req(1, 8'd7, 8'd7);
    set_req(2, 8'd0, 8'd200);
    set_req(3, 8'd255, 8'd255);
    drain();
    chk("s2_count", 32'(order.size()), 4);
    for (int i = 0; i < order.size(); i++) chk("s2_order", 32'(order[i]), i);
    chk("s2_p0", 32'(prod_by[0]), 32'h000F);
    chk("s2_p1", 32'(prod_by[1]), 32'h0031);
    chk("s2_p2", 32'(prod_by[2]), 32'h0000);
    chk("s2_p3", 32'(prod_by[3]), 32'hFE01);
    set_req(1, 8'h11, 8'h02);
    drain();
    order.delete();
    set_req(0, 8'h04, 8'h04);
    set_req(1, 8'h05, 8'h05);
    drain();
    chk("s3_count", 32'(order.size()), 2);
    if (order.size() == 2) begin
      chk("s3_first", 32'(order[0]), 0);
      chk("s3_second", 32'(order[1]), 1);
    end
    stall = 1'b1;
    set_req(2, 8'h09, 8'h09);
    drain();
    stall = 1'b0;
    chk("s4_err", 32'(last_err), 1);
    chk("s4_prod", 32'(last_prod), 0);
    chk("s4_lat", 32'(t_rsp >= TO && t_rsp <= TO + 3), 1);
    set_req(3, 8'h0F, 8'h09);
    drain();
    chk("s4_after_err", 32'(last_err), 0);
    chk("s4_after_prod", 32'(last_prod), 32'h0087);
    lat = 6;
    set_req(0, 8'h10, 8'h10);
    drain();
    chk("s5_prod", 32'(last_prod), 32'h0100);
    chk("s5_lat", 32'(t_rsp > lat), 1);
    lat = 10;
    set_req(2, 8'h33, 8'h44);
    begin
      int n = 0;
      int l0 = n_load;
      while (n_load == l0 && n < 20) begin
        step();
        n++;
      end
      chk("s6_load_seen", 32'(n < 20), 1);
    end
    step();
    #1 reset = 1'b0;
    #1 chk_zero("midrst");
    out_act = 1'b0;
    in_resp = 1'b0;
    ack_sent = 1'b0;
    req_v = '0;
    ptr_m = 0;
    bus.rsp_ack = '0;
    drive();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    lat = 3;
    repeat (12) begin
      step();
      chk("s6_no_rsp", 32'(bus.rsp_valid), 0);
    end
    order.delete();
    set_req(3, 8'h55, 8'h02);
    set_req(0, 8'h0F, 8'h09);
    drain();
    chk("s6_first", 32'(order.size() > 0 ? order[0] : -1), 0);
    chk("s6_prod0", 32'(prod_by[0]), 32'h0087);
    chk("s6_prod3", 32'(prod_by[3]), 32'h00AA);
    for (int c = 0; c < 1500; c++) begin
      if (!out_act) begin
        stall = $urandom_range(0, 11) == 0;
        lat = $urandom_range(1, 6);
      end
      for (int i = 0; i < N; i++) begin
        if (!req_v[i] && $urandom_range(0, 5) == 0) begin
          a_m[i] = 8'($urandom);
          b_m[i] = 8'($urandom);
          req_v[i] = 1'b1;
        end else if (req_v[i] && $urandom_range(0, 40) == 0) req_v[i] = 1'b0;
      end
      drive();
      step();
    end
    stall = 1'b0;
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one 8x8 sequential shift-and-add multiplier among NUM_REQ requesters.
- Arbitrates round-robin and latches the winner's operands.
- Sequences the multiplier: load pulse, then waits for its ready.
- Returns the 16-bit product to the winning requester over a valid/ack handshake. Sits between client blocks and the multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 32, max cycles in WAIT before abort with error.
- IDX_W, 2, requester index width (clog2 of NUM_REQ).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level; held until gnt.
- req_a  in  8*NUM_REQ  packed multiplicand, slice i for requester i.
- req_b  in  8*NUM_REQ  packed multiplier, slice i for requester i.
- gnt  out  NUM_REQ  one-hot, 1-cycle pulse: operands of requester i captured.
- rsp_valid  out  NUM_REQ  one-hot, held until matching rsp_ack.
- rsp_prod  out  16  product for the requester flagged in rsp_valid.
- rsp_err  out  1  qualifies rsp_valid: 1 = timeout, rsp_prod = 0.
- rsp_ack  in  NUM_REQ  requester i consumes response.
- mul_load  out  1  1-cycle pulse; drives multiplier's active-high restart input.
- mul_a  out  8  operand A to multiplier, stable from LOAD to end of WAIT.
- mul_b  out  8  operand B to multiplier, stable from LOAD to end of WAIT.
- mul_prod  in  16  multiplier product.
- mul_ready  in  1  multiplier done flag.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE.
  - gnt, rsp_valid, rsp_prod, rsp_err, mul_load, mul_a, mul_b, busy all 0.
  - Round-robin pointer = 0 (requester 0 highest priority first).
- All outputs registered. States: IDLE, LOAD, WAIT, RESP.
- IDLE:
  - If any req, pick the first set bit searching from pointer upward with wrap.
  - Pulse gnt[winner] for that cycle only.
  - Latch req_a/req_b slice into mul_a/mul_b and the winner index.
  - Next state LOAD.
- LOAD:
  - mul_load=1 for exactly one cycle; clear timeout counter.
  - Next state WAIT.
- WAIT:
  - First cycle after LOAD: ignore mul_ready. It may still show the previous result.
  - From the second WAIT cycle, mul_ready=1 → latch mul_prod into rsp_prod, rsp_err=0, go RESP.
  - Counter reaches TIMEOUT with no ready → rsp_prod=0, rsp_err=1, go RESP.
- RESP:
  - rsp_valid[winner]=1 until rsp_ack[winner]=1.
  - rsp_ack on non-winner bits is ignored.
  - On ack: clear rsp_valid/rsp_err, pointer = winner+1 mod NUM_REQ, go IDLE.
- Latency:
  - Request-to-gnt is 1 cycle from IDLE.
  - gnt to rsp_valid is 3 + multiplier latency (minimum 2 WAIT cycles).
- Requests arriving while busy stay pending; there is no queueing beyond the req level.
- Simultaneous ack and new req: return to IDLE first; the new grant is issued on the following cycle, not in RESP.
- Requester dropping req before gnt: no grant is issued. req sampled only in IDLE.
- Reset asserted mid-operation:
  - Immediate return to IDLE with all outputs 0.
  - In-flight result is discarded; no rsp_valid.
- Arithmetic: unsigned only; product passed through unmodified. 255*255=0xFE01 must pass intact.
- Fairness: after serving i, requester i has lowest priority. With all requesters pending, service order is 0,1,2,3,0,...

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, LOAD=2'd1, WAIT=2'd2, RESP=2'd3), operand width 8, product width 16.
- One natural sub-module: rr_pick.
  - Combinational round-robin priority picker.
  - Inputs: req vector, pointer. Outputs: one-hot winner, index, any.
  - Reusable by other arbiters.
- FSM, operand latches and timeout counter stay in the top module.

Test Plan:
- Single request: req[0]=1, A=0x0F, B=0x09 → one gnt[0] pulse, one mul_load pulse, rsp_valid[0] with rsp_prod=0x0087, rsp_err=0; after rsp_ack[0], busy=0.
- All four requesting simultaneously (operands 3*5, 7*7, 0*200, 255*255) → grant order 0,1,2,3; products 0x000F, 0x0031, 0x0000, 0xFE01, each on the correct rsp_valid bit.
- Fairness wrap: requester 1 served, then req[0] and req[1] both pending → requester 0 granted before 1.
- Timeout: multiplier model holds mul_ready=0 → after TIMEOUT WAIT cycles, rsp_valid[i]=1 with rsp_err=1, rsp_prod=0; next request completes normally.
- Stale-ready guard: mul_ready stuck high from a prior result on the first WAIT cycle → not accepted; product taken only after the model's real completion.
- Reset mid-WAIT: reset low for 2 cycles during WAIT → all outputs 0 immediately, pointer=0, no rsp_valid; a subsequent 15*9 request returns 0x0087.
